// File: rtl/imem_resp.sv
// Instruction-memory responder: one fetch at a time, fixed RD_LAT response latency.
// IMEM_WR_PORT_EN adds a write port; otherwise the array is a ROM built from INIT_IMAGE.
//   state | meaning
//   IDLE  | waiting for i_FetchV, capture address on request
//   WAIT  | latency countdown, array read on the last WAIT edge
//   RESP  | o_TrgtV pulse with registered o_Instr/o_Err
module imem_resp #(
    parameter int          DEPTH     = 256,
    parameter int          RD_LAT    = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
`ifndef IMEM_WR_PORT_EN
    ,
    parameter logic [31:0] INIT_IMAGE [DEPTH] = '{default: 32'h0000_0000}
`endif
) (
    input  logic        i_Clk,
    input  logic        i_RstN,
    input  logic        i_FetchV,
    input  logic [31:0] i_FetchT,
    output logic        o_TrgtV,
    output logic [31:0] o_Instr,
    output logic        o_Err,
    output logic        o_Busy
`ifdef IMEM_WR_PORT_EN
    ,
    input  logic                     i_WrV,
    input  logic [$clog2(DEPTH)-1:0] i_WrA,
    input  logic [31:0]              i_WrD
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    r_State;
    logic [3:0]    r_Cnt;
    logic [31:0]   r_Addr;
    logic [31:0]   r_Instr;
    logic          r_Err;

    logic [31:0]   w_RdAddr;
    logic [31:0]   w_Off;
    logic [AW-1:0] w_Idx;
    logic          w_Err;
    logic [31:0]   w_MemQ;
    logic [31:0]   w_RdData;

    // With RD_LAT=1 the read happens on the capture edge, before r_Addr is loaded.
    assign w_RdAddr = (r_State == IDLE) ? i_FetchT : r_Addr;
    assign w_Off    = w_RdAddr - BASE_ADDR;
    assign w_Idx    = w_Off[AW+1:2];
    assign w_Err    = (|w_Off[1:0]) | (|w_Off[31:AW+2]);

`ifdef IMEM_WR_PORT_EN
    logic [31:0] r_Mem [DEPTH];

    always_ff @(posedge i_Clk) begin
        if (i_WrV) begin
            r_Mem[i_WrA] <= i_WrD;
        end
    end

    assign w_MemQ = r_Mem[w_Idx];
`else
    assign w_MemQ = INIT_IMAGE[w_Idx];
`endif

    assign w_RdData = w_Err ? 32'h0000_0000 : w_MemQ;

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            r_State <= IDLE;
            r_Cnt   <= 4'd0;
            r_Addr  <= 32'h0000_0000;
            r_Instr <= 32'h0000_0000;
            r_Err   <= 1'b0;
        end else begin
            case (r_State)
                IDLE: begin
                    if (i_FetchV) begin
                        r_Addr <= i_FetchT;
                        if (RD_LAT == 1) begin
                            r_State <= RESP;
                            r_Cnt   <= 4'd0;
                            r_Instr <= w_RdData;
                            r_Err   <= w_Err;
                        end else begin
                            r_State <= WAIT;
                            r_Cnt   <= 4'(RD_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_Cnt == 4'd1) begin
                        r_State <= RESP;
                        r_Cnt   <= 4'd0;
                        r_Instr <= w_RdData;
                        r_Err   <= w_Err;
                    end else begin
                        r_Cnt <= r_Cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_State <= IDLE;
                    r_Instr <= 32'h0000_0000;
                    r_Err   <= 1'b0;
                end
                default: begin
                    r_State <= IDLE;
                    r_Cnt   <= 4'd0;
                    r_Instr <= 32'h0000_0000;
                    r_Err   <= 1'b0;
                end
            endcase
        end
    end

    assign o_TrgtV = (r_State == RESP);
    assign o_Busy  = (r_State != IDLE);
    assign o_Instr = r_Instr;
    assign o_Err   = r_Err;

endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: two instances (RD_LAT=2 base 0, RD_LAT=1 base 0x1000) against a
// transaction-level model, plus directed fetches with literal expectations.
module tb_imem_resp;

    localparam logic [31:0] IMG [256] = '{0: 32'h0000_1111, 1: 32'h0000_2222, 2: 32'h0000_3333,
                                          4: 32'hDEAD_BEEF, 7: 32'h0000_7777,
                                          default: 32'h5A5A_A5A5};
    localparam int          LATS  [2] = '{2, 1};
    localparam logic [31:0] BASES [2] = '{32'h0000_0000, 32'h0000_1000};

    logic        clk;
    logic        rstn;
    logic [1:0]  fv;
    logic [31:0] ft [2];
    logic [1:0]  trgtv;
    logic [1:0]  err;
    logic [1:0]  busy;
    logic [31:0] instr [2];
`ifdef IMEM_WR_PORT_EN
    logic        wrv;
    logic [7:0]  wra;
    logic [31:0] wrd;
`endif

    int total = 0;
    int bad   = 0;

    imem_resp #(
        .DEPTH(256), .RD_LAT(2), .BASE_ADDR(32'h0000_0000)
`ifndef IMEM_WR_PORT_EN
        , .INIT_IMAGE(IMG)
`endif
    ) u_dut0 (
        .i_Clk(clk), .i_RstN(rstn), .i_FetchV(fv[0]), .i_FetchT(ft[0]),
        .o_TrgtV(trgtv[0]), .o_Instr(instr[0]), .o_Err(err[0]), .o_Busy(busy[0])
`ifdef IMEM_WR_PORT_EN
        , .i_WrV(wrv), .i_WrA(wra), .i_WrD(wrd)
`endif
    );

    imem_resp #(
        .DEPTH(256), .RD_LAT(1), .BASE_ADDR(32'h0000_1000)
`ifndef IMEM_WR_PORT_EN
        , .INIT_IMAGE(IMG)
`endif
    ) u_dut1 (
        .i_Clk(clk), .i_RstN(rstn), .i_FetchV(fv[1]), .i_FetchT(ft[1]),
        .o_TrgtV(trgtv[1]), .o_Instr(instr[1]), .o_Err(err[1]), .o_Busy(busy[1])
`ifdef IMEM_WR_PORT_EN
        , .i_WrV(wrv), .i_WrA(wra), .i_WrD(wrd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_cnt = edges since capture (0 = idle); response visible when it equals the latency.
    int          m_cnt [2] = '{0, 0};
    logic [31:0] m_addr [2];
    logic [31:0] m_instr [2];
    logic [1:0]  m_err;
    logic [31:0] m_mem [256] = IMG;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k]   = 0;
                m_instr[k] = 32'h0;
                m_err[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] off;
                if (m_cnt[k] == 0) begin
                    if (fv[k]) begin
                        m_cnt[k]  = 1;
                        m_addr[k] = ft[k];
                    end
                end else if (m_cnt[k] == LATS[k]) begin
                    m_cnt[k] = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                if (m_cnt[k] != 0 && m_cnt[k] == LATS[k]) begin
                    off      = m_addr[k] - BASES[k];
                    m_err[k] = (off % 4 != 0) || (off >= 32'd1024);
                    m_instr[k] = m_err[k] ? 32'h0 : m_mem[off / 4];
                end
            end
        end
    end

`ifdef IMEM_WR_PORT_EN
    always @(posedge clk) begin
        if (wrv) m_mem[wra] <= wrd;
    end
`endif

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic exp_v;
            exp_v = (m_cnt[k] != 0) && (m_cnt[k] == LATS[k]);
            total++;
            if (trgtv[k] !== exp_v) begin
                bad++;
                $display("FAIL cmp_trgtv dut%0d t=%0t got=%b want=%b", k, $time, trgtv[k], exp_v);
            end
            total++;
            if (busy[k] !== (m_cnt[k] != 0)) begin
                bad++;
                $display("FAIL cmp_busy dut%0d t=%0t got=%b want=%b", k, $time, busy[k], m_cnt[k] != 0);
            end
            total++;
            if (instr[k] !== (exp_v ? m_instr[k] : 32'h0)) begin
                bad++;
                $display("FAIL cmp_instr dut%0d t=%0t got=%h want=%h", k, $time, instr[k],
                         exp_v ? m_instr[k] : 32'h0);
            end
            if (exp_v) begin
                total++;
                if (err[k] !== m_err[k]) begin
                    bad++;
                    $display("FAIL cmp_err dut%0d t=%0t got=%b want=%b", k, $time, err[k], m_err[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic wait_trgtv(input int k, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (trgtv[k] !== 1'b1 && n < 40);
    endtask

    task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] ex_instr,
                         input logic ex_err, input string nm);
        int n;
        ft[k] = a;
        fv[k] = 1'b1;
        wait_trgtv(k, n);
        fv[k] = 1'b0;
        chk({nm, "_lat"}, n, LATS[k]);
        chk({nm, "_instr"}, instr[k], ex_instr);
        chk({nm, "_err"}, {31'b0, err[k]}, {31'b0, ex_err});
        @(negedge clk);
    endtask

    task automatic b2b(input int k, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input string nm);
        logic [31:0] as [3];
        logic [31:0] ds [3];
        int n;
        as = '{a0, a1, a2};
        ds = '{d0, d1, d2};
        fv[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ft[k] = as[i];
            wait_trgtv(k, n);
            chk($sformatf("%s_gap%0d", nm, i), n, (i == 0) ? LATS[k] : LATS[k] + 1);
            chk($sformatf("%s_instr%0d", nm, i), instr[k], ds[i]);
        end
        fv[k] = 1'b0;
        @(negedge clk);
    endtask

`ifdef IMEM_WR_PORT_EN
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wrv = 1'b1;
        wra = a;
        wrd = d;
        @(negedge clk);
        wrv = 1'b0;
    endtask
`endif

    initial begin
        int n;
        rstn  = 1'b0;
        fv    = 2'b00;
        ft[0] = 32'h0;
        ft[1] = 32'h0;
`ifdef IMEM_WR_PORT_EN
        wrv = 1'b0;
        wra = 8'h0;
        wrd = 32'h0;
`endif
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_trgtv%0d", k), {31'b0, trgtv[k]}, 32'h0);
            chk($sformatf("rst_instr%0d", k), instr[k], 32'h0);
            chk($sformatf("rst_err%0d", k), {31'b0, err[k]}, 32'h0);
            chk($sformatf("rst_busy%0d", k), {31'b0, busy[k]}, 32'h0);
        end
        rstn = 1'b1;
        @(negedge clk);

`ifdef IMEM_WR_PORT_EN
        for (int i = 0; i < 256; i++) wr(8'(i), IMG[i]);
        @(negedge clk);
`endif

        fetch(0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "l2_word4");
        fetch(0, 32'h0000_0012, 32'h0000_0000, 1'b1, "l2_misalign");
        fetch(0, 32'h0000_0400, 32'h0000_0000, 1'b1, "l2_range");
        fetch(0, 32'h0000_03FC, 32'h5A5A_A5A5, 1'b0, "l2_lastword");
        fetch(0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, "l2_wrap");
        b2b(0, 32'h0, 32'h4, 32'h8, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, "l2_b2b");

        fetch(1, 32'h0000_1010, 32'hDEAD_BEEF, 1'b0, "l1_word4");
        fetch(1, 32'h0000_0FFC, 32'h0000_0000, 1'b1, "l1_below");
        fetch(1, 32'h0000_13FC, 32'h5A5A_A5A5, 1'b0, "l1_lastword");
        fetch(1, 32'h0000_1400, 32'h0000_0000, 1'b1, "l1_range");
        b2b(1, 32'h1000, 32'h1004, 32'h1011, 32'h0000_1111, 32'h0000_2222, 32'h0, "l1_b2b");

        // reset pulse while dut0 sits in WAIT
        ft[0] = 32'h0000_0010;
        fv[0] = 1'b1;
        @(negedge clk);
        chk("midrst_busy_before", {31'b0, busy[0]}, 32'h1);
        #2;
        rstn  = 1'b0;
        fv[0] = 1'b0;
        #1;
        chk("midrst_trgtv", {31'b0, trgtv[0]}, 32'h0);
        chk("midrst_busy", {31'b0, busy[0]}, 32'h0);
        chk("midrst_instr", instr[0], 32'h0);
        chk("midrst_err", {31'b0, err[0]}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (trgtv[0] === 1'b1) n++;
        end
        chk("midrst_no_pulse", n, 0);
        fetch(0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "postrst_word4");

`ifdef IMEM_WR_PORT_EN
        wr(8'd7, 32'h1234_5678);
        fetch(0, 32'h0000_001C, 32'h1234_5678, 1'b0, "wr_then_rd");
        // write lands on the same edge dut0 reads index 7: old data expected
        ft[0] = 32'h0000_001C;
        fv[0] = 1'b1;
        @(negedge clk);
        wrv = 1'b1;
        wra = 8'd7;
        wrd = 32'hCAFE_F00D;
        @(negedge clk);
        wrv = 1'b0;
        fv[0] = 1'b0;
        chk("collide_trgtv", {31'b0, trgtv[0]}, 32'h1);
        chk("collide_instr", instr[0], 32'h1234_5678);
        @(negedge clk);
        fetch(0, 32'h0000_001C, 32'hCAFE_F00D, 1'b0, "after_collide");
        fetch(1, 32'h0000_101C, 32'hCAFE_F00D, 1'b0, "l1_after_collide");
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
